// File: rtl/add_operand_seq.sv
// add_operand_seq: operand sequencer and result register for an external
// 4-bit combinational ripple-carry adder.
// Two load-button presses capture operand A, then operand B together with
// carry-in. The adder gets one full cycle to settle, and then its sum and
// carry-out are registered with zero and signed-overflow flags.
//
// Optional build macro: ADD_SEQ_DEBOUNCE_EN adds a stable-level debounce
// counter after each button synchroniser.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   sw, cin_sw         operand / carry-in switches, sampled at a load event
//   load_btn, clr_btn  asynchronous active-high buttons
//   op_a, op_b, op_cin operands and carry-in driven to the adder (registered)
//   sum_in, cout_in    combinational adder result
//   result             registered {cout, sum}
//   result_valid       high while result holds a completed addition
//   zero, ovf          registered result flags
//   state              FSM state for debug LEDs
module add_operand_seq #(
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned DEBOUNCE_CYC = 1000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] sw,
    input  logic       cin_sw,
    input  logic       load_btn,
    input  logic       clr_btn,
    output logic [3:0] op_a,
    output logic [3:0] op_b,
    output logic       op_cin,
    input  logic [3:0] sum_in,
    input  logic       cout_in,
    output logic [4:0] result,
    output logic       result_valid,
    output logic       zero,
    output logic       ovf,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GOT_A = 2'd1,
        EXEC  = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam int unsigned N_BTN = 2;

    // Index 0 = load, index 1 = clear
    logic [N_BTN-1:0] btn_raw;
    logic [N_BTN-1:0] btn_evt_c;

    assign btn_raw = {clr_btn, load_btn};

    // Per-button synchroniser, optional debounce, and rising-edge detector
    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        logic [SYNC_STAGES-1:0] sync_q, sync_d;
        logic                   lvl_c;
        logic                   prev_q, prev_d;

        always_comb begin
            sync_d = {sync_q[SYNC_STAGES-2:0], btn_raw[i]};
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sync_q <= '0;
            end else begin
                sync_q <= sync_d;
            end
        end

`ifdef ADD_SEQ_DEBOUNCE_EN
        localparam int unsigned CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;

        logic             acc_q, acc_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;

        // Accepted level flips only after DEBOUNCE_CYC consecutive
        // differing cycles; any agreeing cycle restarts the count.
        always_comb begin
            acc_d = acc_q;
            cnt_d = '0;
            if (sync_q[SYNC_STAGES-1] != acc_q) begin
                if (cnt_q == CNT_W'(DEBOUNCE_CYC - 1)) begin
                    acc_d = sync_q[SYNC_STAGES-1];
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                acc_q <= 1'b0;
                cnt_q <= '0;
            end else begin
                acc_q <= acc_d;
                cnt_q <= cnt_d;
            end
        end

        assign lvl_c = acc_q;
`else
        assign lvl_c = sync_q[SYNC_STAGES-1];
`endif

        always_comb begin
            prev_d = lvl_c;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                prev_q <= 1'b0;
            end else begin
                prev_q <= prev_d;
            end
        end

        assign btn_evt_c[i] = lvl_c & ~prev_q;
    end

    logic load_evt_c;
    logic clr_evt_c;

    assign load_evt_c = btn_evt_c[0];
    assign clr_evt_c  = btn_evt_c[1];

    state_e     state_q, state_d;
    logic [3:0] op_a_q, op_a_d;
    logic [3:0] op_b_q, op_b_d;
    logic       op_cin_q, op_cin_d;
    logic [4:0] result_q, result_d;
    logic       valid_q, valid_d;
    logic       zero_q, zero_d;
    logic       ovf_q, ovf_d;

    // Sequencer next-state; clear overrides a coincident load
    always_comb begin
        state_d  = state_q;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        op_cin_d = op_cin_q;
        result_d = result_q;
        valid_d  = valid_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;

        if (clr_evt_c) begin
            valid_d = 1'b0;
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (load_evt_c) begin
                        op_a_d  = sw;
                        state_d = GOT_A;
                    end
                end
                GOT_A: begin
                    if (load_evt_c) begin
                        op_b_d   = sw;
                        op_cin_d = cin_sw;
                        state_d  = EXEC;
                    end
                end
                EXEC: begin
                    // Adder has had a full cycle on the registered operands
                    result_d = {cout_in, sum_in};
                    zero_d   = (sum_in == 4'd0);
                    ovf_d    = (op_a_q[3] == op_b_q[3]) && (sum_in[3] != op_a_q[3]);
                    valid_d  = 1'b1;
                    state_d  = DONE;
                end
                DONE: begin
                    if (load_evt_c) begin
                        op_a_d  = sw;
                        valid_d = 1'b0;
                        state_d = GOT_A;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            op_a_q   <= '0;
            op_b_q   <= '0;
            op_cin_q <= 1'b0;
            result_q <= '0;
            valid_q  <= 1'b0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            op_cin_q <= op_cin_d;
            result_q <= result_d;
            valid_q  <= valid_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
        end
    end

    assign op_a         = op_a_q;
    assign op_b         = op_b_q;
    assign op_cin       = op_cin_q;
    assign result       = result_q;
    assign result_valid = valid_q;
    assign zero         = zero_q;
    assign ovf          = ovf_q;
    assign state        = state_q;

endmodule

// File: tb/tb_add_operand_seq.sv
// tb_add_operand_seq: self-checking bench for add_operand_seq. Models the
// external adder and keeps a behavioural reference of the operand sequence.
module tb_add_operand_seq;

    localparam int unsigned S  = 2;
    localparam int unsigned DB = 8;
`ifdef ADD_SEQ_DEBOUNCE_EN
    localparam int unsigned DB_LAT = DB;
`else
    localparam int unsigned DB_LAT = 0;
`endif
    localparam int unsigned HOLD   = DB_LAT + 3;
    localparam int unsigned SETTLE = S + DB_LAT + 5;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] sw;
    logic       cin_sw;
    logic       load_btn;
    logic       clr_btn;
    logic [3:0] op_a, op_b;
    logic       op_cin;
    logic [3:0] sum_in;
    logic       cout_in;
    logic [4:0] result;
    logic       result_valid;
    logic       zero, ovf;
    logic [1:0] state;

    int n_tests = 0;
    int n_fail  = 0;

    add_operand_seq #(.SYNC_STAGES(S), .DEBOUNCE_CYC(DB)) dut (
        .clk(clk), .rst_n(rst_n), .sw(sw), .cin_sw(cin_sw),
        .load_btn(load_btn), .clr_btn(clr_btn),
        .op_a(op_a), .op_b(op_b), .op_cin(op_cin),
        .sum_in(sum_in), .cout_in(cout_in),
        .result(result), .result_valid(result_valid),
        .zero(zero), .ovf(ovf), .state(state)
    );

    // External combinational adder
    assign {cout_in, sum_in} = 5'(op_a) + 5'(op_b) + 5'(op_cin);

    always #5 clk = ~clk;

    // Reference model of the visible register state
    logic [3:0] m_a, m_b;
    logic       m_cin;
    logic [4:0] m_res;
    logic       m_valid, m_zero, m_ovf;
    int         m_state;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic m_reset();
        m_a = 0; m_b = 0; m_cin = 0; m_res = 0;
        m_valid = 0; m_zero = 0; m_ovf = 0; m_state = 0;
    endtask

    task automatic m_load(input logic [3:0] s, input logic c);
        int tot, sa, sb, ss;
        case (m_state)
            0: begin m_a = s; m_state = 1; end
            1: begin
                m_b = s; m_cin = c;
                tot = int'(m_a) + int'(m_b) + int'(m_cin);
                sa  = (m_a >= 8) ? int'(m_a) - 16 : int'(m_a);
                sb  = (m_b >= 8) ? int'(m_b) - 16 : int'(m_b);
                ss  = sa + sb + int'(m_cin);
                m_res   = 5'(tot);
                m_zero  = ((tot % 16) == 0);
                m_ovf   = (ss > 7) || (ss < -8);
                m_valid = 1;
                m_state = 3;
            end
            3: begin m_a = s; m_valid = 0; m_state = 1; end
            default: ;
        endcase
    endtask

    task automatic check_all(input string tag);
        check({tag, ".op_a"},   32'(op_a),         32'(m_a));
        check({tag, ".op_b"},   32'(op_b),         32'(m_b));
        check({tag, ".op_cin"}, 32'(op_cin),       32'(m_cin));
        check({tag, ".result"}, 32'(result),       32'(m_res));
        check({tag, ".valid"},  32'(result_valid), 32'(m_valid));
        check({tag, ".zero"},   32'(zero),         32'(m_zero));
        check({tag, ".ovf"},    32'(ovf),          32'(m_ovf));
        check({tag, ".state"},  32'(state),        32'(m_state));
    endtask

    // Press buttons from a negedge, hold, release and let everything settle
    task automatic press(input logic [3:0] s, input logic c, input bit ld, input bit cl, input int hold);
        sw = s; cin_sw = c; load_btn = ld; clr_btn = cl;
        repeat (hold) @(negedge clk);
        load_btn = 0; clr_btn = 0;
        repeat (SETTLE) @(negedge clk);
        if (cl) m_clr();
        else if (ld) m_load(s, c);
    endtask

    task automatic m_clr();
        m_valid = 0; m_state = 0;
    endtask

    initial begin
        int n;
        logic [3:0] rs;
        logic       rc;
        int         r;

        rst_n = 0; sw = 0; cin_sw = 0; load_btn = 0; clr_btn = 0;
        m_reset();
        repeat (3) @(negedge clk);
        check_all("reset");
        rst_n = 1;
        repeat (2) @(negedge clk);

        // 7 + 9 + 0, measuring result latency from the B press
        press(4'h7, 1'b0, 1, 0, HOLD);
        check_all("load_a7");
        sw = 4'h9; cin_sw = 0; load_btn = 1;
        n = 0;
        while (n < 60) begin
            @(posedge clk); #1; n++;
            if (result_valid === 1'b1) break;
        end
        check("b_to_valid_latency", 32'(n), 32'(S + DB_LAT + 2));
        @(negedge clk);
        load_btn = 0;
        repeat (SETTLE) @(negedge clk);
        m_load(4'h9, 1'b0);
        check_all("add_7_9");
        check("add_7_9.result_const", 32'(result), 32'h10);
        check("add_7_9.zero_const", 32'(zero), 32'd1);

        // Clear and load together in DONE: clear wins, data held
        press(4'h3, 1'b1, 1, 1, HOLD);
        check_all("clr_load_same");
        check("clr_load_same.result_const", 32'(result), 32'h10);
        check("clr_load_same.op_a_const", 32'(op_a), 32'h7);

        // Held load button gives exactly one event
        press(4'h3, 1'b0, 1, 0, 50);
        check_all("held_50");
        check("held_50.state_const", 32'(state), 32'd1);

        // 7 + 1 + 1 overflows into the sign bit
        press(4'h0, 1'b0, 0, 1, HOLD);
        press(4'h7, 1'b0, 1, 0, HOLD);
        press(4'h1, 1'b1, 1, 0, HOLD);
        check_all("add_7_1_c");
        check("add_7_1_c.result_const", 32'(result), 32'h09);
        check("add_7_1_c.ovf_const", 32'(ovf), 32'd1);

        // Reload from DONE keeps result, then async reset mid-GOT_A
        press(4'h5, 1'b0, 1, 0, HOLD);
        check_all("reload_from_done");
        #2 rst_n = 0;
        #1;
        m_reset();
        check_all("async_rst");
        repeat (2) @(negedge clk);
        rst_n = 1;
        repeat (2) @(negedge clk);

`ifdef ADD_SEQ_DEBOUNCE_EN
        // Bouncing shorter than the debounce window produces no event
        sw = 4'hA;
        for (int k = 0; k < 4; k++) begin
            load_btn = 1; repeat (5) @(negedge clk);
            load_btn = 0; repeat (5) @(negedge clk);
        end
        check("bounce_no_evt.state", 32'(state), 32'd0);
`endif

        // Button-to-event latency from IDLE
        sw = 4'hA; cin_sw = 0; load_btn = 1;
        n = 0;
        while (n < 60) begin
            @(posedge clk); #1; n++;
            if (state !== 2'd0) break;
        end
        check("load_evt_latency", 32'(n), 32'(S + DB_LAT + 1));
        @(negedge clk);
        repeat (2) @(negedge clk);
        load_btn = 0;
        repeat (SETTLE) @(negedge clk);
        m_load(4'hA, 1'b0);
        check_all("latency_capture");

        // Random load/clear sequences against the model
        for (int i = 0; i < 40; i++) begin
            r  = int'($urandom_range(0, 9));
            rs = 4'($urandom_range(0, 15));
            rc = 1'($urandom_range(0, 1));
            press(rs, rc, (r != 1), (r < 2), HOLD);
            check_all($sformatf("rand%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
